fixed_point_mac: RTL



---
 rtl/fixed_point_pkg.sv | 53 +++++
 rtl/sm_mag_multiplier.sv | 46 ++++
 rtl/fixed_point_mac.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fixed_point_pkg.sv
// Shared constants, state encoding and sign-magnitude helpers for fixed_point_mac.
// Build option FIXED_POINT_MAC_SATURATE_EN selects clamping instead of wrapping on overflow.
package fixed_point_pkg;

   localparam int unsigned QM       = 17;
   localparam int unsigned QN       = 16;
   localparam int unsigned AccGuard = 8;

   localparam int unsigned W      = QM + QN;
   localparam int unsigned ACC_W  = W + AccGuard;
   localparam int unsigned WIDE_W = 2 * W;

   localparam logic [W-1:0] MAG_MAX = {1'b0, {(W-1){1'b1}}};

   typedef enum logic [1:0] {
      StAccum,
      StFlush,
      StDone
   } state_e;

   typedef struct packed {
      logic         ovf;
      logic [W-1:0] sm;
   } sm_res_t;

   // Squeeze a wide unsigned magnitude into W-bit sign-magnitude.
   function automatic sm_res_t fit_sm(input logic sign, input logic [WIDE_W-1:0] mag);
      sm_res_t      res;
      logic [W-2:0] m;
      res.ovf = |mag[WIDE_W-1:W-1];
`ifdef FIXED_POINT_MAC_SATURATE_EN
      m = res.ovf ? MAG_MAX[W-2:0] : mag[W-2:0];
`else
      m = mag[W-2:0];
`endif
      // a zero magnitude never carries a sign
      res.sm = {sign & (|m), m};
      return res;
   endfunction

   function automatic logic [ACC_W-1:0] sm_to_tc(input logic [W-1:0] sm);
      logic [ACC_W-1:0] mag;
      mag = {{(ACC_W-W+1){1'b0}}, sm[W-2:0]};
      return sm[W-1] ? -mag : mag;
   endfunction

   function automatic sm_res_t tc_to_sm(input logic [ACC_W-1:0] v);
      logic [ACC_W-1:0] mag;
      mag = v[ACC_W-1] ? -v : v;
      return fit_sm(v[ACC_W-1], {{(WIDE_W-ACC_W){1'b0}}, mag});
   endfunction

endpackage

// File: rtl/sm_mag_multiplier.sv
// Sign-magnitude fixed-point product with overflow detect, registered as pipeline stage 1.
// Honours FIXED_POINT_MAC_SATURATE_EN through fixed_point_pkg::fit_sm.
module sm_mag_multiplier
   import fixed_point_pkg::*;
#(
   parameter int unsigned q_n = QN
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         en_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         last_i,
   output logic         p_valid_o,
   output logic         p_last_o,
   output logic         p_ovf_o,
   output logic [W-1:0] p_sm_o
);

   logic [2*W-3:0]    prod;
   logic [WIDE_W-1:0] prod_shifted;
   sm_res_t           prod_fit;

   always_comb begin
      prod         = {{(W-1){1'b0}}, a_i[W-2:0]} * {{(W-1){1'b0}}, b_i[W-2:0]};
      prod_shifted = {2'b00, prod >> q_n};
      prod_fit     = fit_sm(a_i[W-1] ^ b_i[W-1], prod_shifted);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         p_valid_o <= 1'b0;
         p_last_o  <= 1'b0;
         p_ovf_o   <= 1'b0;
         p_sm_o    <= '0;
      end else begin
         p_valid_o <= en_i;
         if (en_i) begin
            p_last_o <= last_i;
            p_ovf_o  <= prod_fit.ovf;
            p_sm_o   <= prod_fit.sm;
         end
      end
   end

endmodule

// File: rtl/fixed_point_mac.sv
// Pipelined sign-magnitude multiply-accumulate: one dot-product result per last_i-delimited vector.
// Define FIXED_POINT_MAC_SATURATE_EN to clamp on overflow; the default build wraps.
module fixed_point_mac
   import fixed_point_pkg::*;
#(
   parameter int unsigned q_m       = QM,
   parameter int unsigned q_n       = QN,
   parameter int unsigned ACC_GUARD = AccGuard
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [q_m+q_n-1:0] a_in,
   input  logic [q_m+q_n-1:0] b_in,
   input  logic               last_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [q_m+q_n-1:0] y_out,
   output logic               ovf_o
);

   localparam int unsigned DataW = q_m + q_n;
   localparam int unsigned AccW  = DataW + ACC_GUARD;

   state_e           state_q, state_d;
   logic [AccW-1:0]  acc_q, acc_d;
   logic [DataW-1:0] y_q, y_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic             p_valid, p_last, p_ovf;
   logic [DataW-1:0] p_sm;
   logic [AccW-1:0]  p_tc, sum, sum_fit;
   logic             add_ovf;
   sm_res_t          res;

   assign accept = valid_i && ready_o;

   sm_mag_multiplier #(
      .q_n (q_n)
   ) u_mul (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .en_i      (accept),
      .a_i       (a_in),
      .b_i       (b_in),
      .last_i    (last_i),
      .p_valid_o (p_valid),
      .p_last_o  (p_last),
      .p_ovf_o   (p_ovf),
      .p_sm_o    (p_sm)
   );

   // Stage 2 adder; signed overflow when both operands agree in sign and the sum does not.
   always_comb begin
      p_tc    = sm_to_tc(p_sm);
      sum     = acc_q + p_tc;
      add_ovf = (acc_q[AccW-1] == p_tc[AccW-1]) && (sum[AccW-1] != acc_q[AccW-1]);
`ifdef FIXED_POINT_MAC_SATURATE_EN
      if (add_ovf) begin
         sum_fit = acc_q[AccW-1] ? {1'b1, {(AccW-1){1'b0}}} : {1'b0, {(AccW-1){1'b1}}};
      end else begin
         sum_fit = sum;
      end
`else
      sum_fit = sum;
`endif
      res = tc_to_sm(sum_fit);
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      y_d     = y_q;
      ovf_d   = ovf_q;
      ready_o = 1'b0;
      valid_o = 1'b0;
      unique case (state_q)
         StAccum: begin
            ready_o = 1'b1;
            if (p_valid) begin
               acc_d = sum_fit;
               ovf_d = ovf_q | p_ovf | add_ovf;
            end
            if (accept && last_i) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            // The last product is in stage 1 now: fold it in and convert in one step.
            if (p_valid && p_last) begin
               y_d     = res.sm;
               ovf_d   = ovf_q | p_ovf | add_ovf | res.ovf;
               acc_d   = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            valid_o = 1'b1;
            if (ready_i) begin
               ovf_d   = 1'b0;
               state_d = StAccum;
            end
         end
         default: state_d = StAccum;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StAccum;
         acc_q   <= '0;
         y_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         ovf_q   <= ovf_d;
      end
   end

   assign y_out = y_q;
   assign ovf_o = ovf_q;

endmodule
